ser_arbiter: RTL and testbench
==============================

SER_ARBITER -- requirements
Module: ser_arbiter

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, number of requester channels (2..8).
REQ-002 SHALL have parameter DATA_W, default 16, serializer parallel word width.
REQ-003 SHALL have port clk_i  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req_data_i  input  CH_NUM x DATA_W  per-channel parallel word.
REQ-006 SHALL have port req_mod_i  input  CH_NUM x 4  per-channel bit count (0 means 16).
REQ-007 SHALL have port req_val_i  input  CH_NUM  per-channel request valid.
REQ-008 SHALL have port req_ready_o  output  CH_NUM  per-channel holding register empty.
REQ-009 SHALL have port ser_data_o  output  DATA_W  word driven to the serializer.
REQ-010 SHALL have port ser_mod_o  output  4  mod driven to the serializer.
REQ-011 SHALL have port ser_val_o  output  1  one-cycle start strobe to the serializer.
REQ-012 SHALL have port ser_busy_i  input  1  serializer busy flag.
REQ-013 SHALL have port grant_id_o  output  $clog2(CH_NUM)  channel currently owning the serializer.
REQ-014 SHALL have port drop_o  output  1  one-cycle pulse when a word is discarded.

Function
REQ-015 Each channel SHALL have a one-entry holding register, loaded when req_val_i and req_ready_o are both high; req_ready_o SHALL be low while the register is full.
REQ-016 mod values 1 and 2 are invalid; such a word SHALL be accepted but not issued, and SHALL raise drop_o for one cycle on the cycle the register is freed.
REQ-017 FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE.
REQ-018 In IDLE, if any valid holding register is full, SHALL grant round-robin starting at the channel after the last grant, and go to ISSUE next cycle.
REQ-019 In ISSUE, SHALL assert ser_val_o for exactly one cycle with ser_data_o/ser_mod_o from the granted register, free that register, and go to WAIT_START.
REQ-020 In WAIT_START, ser_busy_i high SHALL move to WAIT_DONE; if ser_busy_i stays low for 2 cycles, SHALL pulse drop_o and return to IDLE.
REQ-021 In WAIT_DONE, ser_busy_i low SHALL return to IDLE; the next issue SHALL occur no earlier than 2 cycles after busy falls.
REQ-022 ser_data_o/ser_mod_o SHALL hold their last issued values outside ISSUE, and ser_val_o SHALL be 0 outside ISSUE.
REQ-023 A channel's load and free in the same cycle SHALL leave the register full with the new word.
REQ-024 Round-robin pointer SHALL wrap from CH_NUM-1 to 0 and SHALL update only in ISSUE.
REQ-025 A channel SHALL NOT be granted twice while another full channel waits.

Reset
REQ-026 On rst_i, SHALL immediately set state IDLE, all holding registers empty, req_ready_o all 1, ser_val_o 0, ser_data_o 0, ser_mod_o 0, grant_id_o 0, drop_o 0, RR pointer 0.
REQ-027 Reset mid-transfer SHALL abandon the transfer; nothing SHALL be issued until two cycles after rst_i deasserts.

Structure
REQ-028 Package ser_arb_pkg SHALL hold the state enum, MOD_INV1=1, MOD_INV2=2, and START_TIMEOUT=2.
REQ-029 Sub-module rr_arbiter (request vector, pointer -> one-hot grant and index) SHALL be instantiated once.

Verification
REQ-030 Channel 0 sends 0xA5A5, mod 0 -> ser_val_o is 1 for one cycle carrying 0xA5A5, and grant_id_o is 0.
REQ-031 All 4 channels request at once -> grants issue in order 0,1,2,3, each after the previous busy falls.
REQ-032 Channel 2 sends mod 1 -> no ser_val_o, one drop_o pulse, and req_ready_o[2] returns to 1.
REQ-033 ser_busy_i is held at 0 after an issue -> drop_o pulses 2 cycles after the issue, and the FSM returns to IDLE.
REQ-034 rst_i asserts during WAIT_DONE -> all outputs are at reset values in the same cycle, and no issue occurs within 2 cycles after release.

Source files
------------

// File: rtl/ser_arb_pkg.sv
// ser_arb_pkg: shared types and constants for the serializer arbiter.
package ser_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;
    localparam logic [3:0] MOD_INV1 = 4'd1;
    localparam logic [3:0] MOD_INV2 = 4'd2;
    localparam int START_TIMEOUT = 2;
    function automatic logic is_inv(input logic [3:0] m);
        return (m == MOD_INV1) || (m == MOD_INV2);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first request at or after ptr, wrapping, as one-hot and index.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    int j;
    logic [IW-1:0] k;
    // Scan farthest offset first so the nearest request after ptr wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        j = 0;
        k = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % N;
            k = IW'(j);
            if (req[k]) begin
                gnt = '0;
                gnt[k] = 1'b1;
                idx = k;
            end
        end
    end
endmodule

// File: rtl/ser_arbiter.sv
// ser_arbiter: one-entry holding register per channel, round-robin issue to a shared serializer.
module ser_arbiter
    import ser_arb_pkg::*;
#(
    parameter int CH_NUM = 4,
    parameter int DATA_W = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [CH_NUM-1:0][DATA_W-1:0]    req_data_i,
    input  logic [CH_NUM-1:0][3:0]           req_mod_i,
    input  logic [CH_NUM-1:0]                req_val_i,
    output logic [CH_NUM-1:0]                req_ready_o,
    output logic [DATA_W-1:0]                ser_data_o,
    output logic [3:0]                       ser_mod_o,
    output logic                             ser_val_o,
    input  logic                             ser_busy_i,
    output logic [$clog2(CH_NUM)-1:0]        grant_id_o,
    output logic                             drop_o
);
    localparam int IW = $clog2(CH_NUM);

    state_t state_q, state_d;
    logic [CH_NUM-1:0] full_q, inv, vld, gnt_oh, own_q;
    logic [CH_NUM-1:0][DATA_W-1:0] data_q;
    logic [CH_NUM-1:0][3:0] mod_q;
    logic [IW-1:0] ptr_q, gnt_idx;
    logic [1:0] cnt_q;
    logic timeout, take;

    always_comb begin
        inv = '0;
        for (int i = 0; i < CH_NUM; i++) inv[i] = full_q[i] && is_inv(mod_q[i]);
    end

    assign vld         = full_q & ~inv;
    assign take        = (state_q == IDLE) && (|vld);
    assign timeout     = (state_q == WAIT_START) && !ser_busy_i && (cnt_q == 2'(START_TIMEOUT - 1));
    assign req_ready_o = ~full_q;
    assign ser_val_o   = (state_q == ISSUE);
    assign drop_o      = (|inv) || timeout;

    rr_arbiter #(.N(CH_NUM)) u_rr (
        .req(vld),
        .ptr(ptr_q),
        .gnt(gnt_oh),
        .idx(gnt_idx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       state_d = take ? ISSUE : IDLE;
            ISSUE:      state_d = WAIT_START;
            WAIT_START: state_d = ser_busy_i ? WAIT_DONE : (timeout ? IDLE : WAIT_START);
            WAIT_DONE:  state_d = ser_busy_i ? WAIT_DONE : IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q     <= '0;
            data_q     <= '0;
            mod_q      <= '0;
            own_q      <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            grant_id_o <= '0;
            ser_data_o <= '0;
            ser_mod_o  <= '0;
        end else begin
            cnt_q <= (state_q == WAIT_START) ? cnt_q + 2'd1 : 2'd0;
            if (take) begin
                own_q      <= gnt_oh;
                grant_id_o <= gnt_idx;
                ser_data_o <= data_q[gnt_idx];
                ser_mod_o  <= mod_q[gnt_idx];
            end
            if (state_q == ISSUE)
                ptr_q <= (grant_id_o == IW'(CH_NUM - 1)) ? '0 : grant_id_o + IW'(1);
            // Invalid-mod words are released the cycle after they land, never arbitrated.
            for (int i = 0; i < CH_NUM; i++) begin
                if (req_val_i[i] && !full_q[i]) begin
                    full_q[i] <= 1'b1;
                    data_q[i] <= req_data_i[i];
                    mod_q[i]  <= req_mod_i[i];
                end else if (((state_q == ISSUE) && own_q[i]) || inv[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ser_arbiter.sv
// tb_ser_arbiter: directed per-cycle vector table plus hand-written reset sequences.
module tb_ser_arbiter;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic [3:0][15:0] req_data_i;
    logic [3:0][3:0] req_mod_i;
    logic [3:0] req_val_i = '0;
    logic [3:0] req_ready_o;
    logic [15:0] ser_data_o;
    logic [3:0] ser_mod_o;
    logic ser_val_o;
    logic ser_busy_i = 1'b0;
    logic [1:0] grant_id_o;
    logic drop_o;

    typedef struct {
        logic [3:0]  val;
        logic [3:0]  mod;
        logic        busy;
        logic [3:0]  rdy;
        logic        sv;
        logic [15:0] sd;
        logic [3:0]  sm;
        logic [1:0]  gid;
        logic        drp;
    } vec_t;

    vec_t vq[$];
    int n_vec = 0;
    int n_err = 0;

    ser_arbiter #(.CH_NUM(4), .DATA_W(16)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .req_data_i(req_data_i),
        .req_mod_i(req_mod_i),
        .req_val_i(req_val_i),
        .req_ready_o(req_ready_o),
        .ser_data_o(ser_data_o),
        .ser_mod_o(ser_mod_o),
        .ser_val_o(ser_val_o),
        .ser_busy_i(ser_busy_i),
        .grant_id_o(grant_id_o),
        .drop_o(drop_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic add(input logic [3:0] val, input logic [3:0] mod, input logic busy,
                       input logic [3:0] rdy, input logic sv, input logic [15:0] sd,
                       input logic [3:0] sm, input logic [1:0] gid, input logic drp);
        vec_t r;
        r = '{val, mod, busy, rdy, sv, sd, sm, gid, drp};
        vq.push_back(r);
    endtask

    task automatic chk(input string name, input logic [3:0] rdy, input logic sv, input logic [15:0] sd,
                       input logic [3:0] sm, input logic [1:0] gid, input logic drp);
        n_vec++;
        if ({req_ready_o, ser_val_o, ser_data_o, ser_mod_o, grant_id_o, drop_o} !== {rdy, sv, sd, sm, gid, drp}) begin
            n_err++;
            $display("FAIL %s: got rdy=%b val=%b data=%h mod=%h gid=%0d drop=%b, expected rdy=%b val=%b data=%h mod=%h gid=%0d drop=%b",
                     name, req_ready_o, ser_val_o, ser_data_o, ser_mod_o, grant_id_o, drop_o, rdy, sv, sd, sm, gid, drp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        req_data_i = {16'h3333, 16'h2222, 16'h1111, 16'hA5A5};
        req_mod_i = '0;
        // All four channels at once, then serviced 0,1,2,3 after each busy fall.
        add(4'hF, 0, 0, 4'b0000, 0, 16'h0000, 0, 0, 0);
        add(4'h0, 0, 0, 4'b0000, 1, 16'hA5A5, 0, 0, 0);
        add(4'h0, 0, 0, 4'b0001, 0, 16'hA5A5, 0, 0, 0);
        add(4'h0, 0, 1, 4'b0001, 0, 16'hA5A5, 0, 0, 0);
        add(4'h0, 0, 0, 4'b0001, 0, 16'hA5A5, 0, 0, 0);
        add(4'h0, 0, 0, 4'b0001, 1, 16'h1111, 0, 1, 0);
        add(4'h0, 0, 0, 4'b0011, 0, 16'h1111, 0, 1, 0);
        add(4'h0, 0, 1, 4'b0011, 0, 16'h1111, 0, 1, 0);
        add(4'h0, 0, 0, 4'b0011, 0, 16'h1111, 0, 1, 0);
        add(4'h0, 0, 0, 4'b0011, 1, 16'h2222, 0, 2, 0);
        add(4'h0, 0, 0, 4'b0111, 0, 16'h2222, 0, 2, 0);
        add(4'h0, 0, 1, 4'b0111, 0, 16'h2222, 0, 2, 0);
        add(4'h0, 0, 0, 4'b0111, 0, 16'h2222, 0, 2, 0);
        add(4'h0, 0, 0, 4'b0111, 1, 16'h3333, 0, 3, 0);
        add(4'h0, 0, 0, 4'b1111, 0, 16'h3333, 0, 3, 0);
        add(4'h0, 0, 1, 4'b1111, 0, 16'h3333, 0, 3, 0);
        add(4'h0, 0, 0, 4'b1111, 0, 16'h3333, 0, 3, 0);
        // Single word on channel 0
        add(4'h1, 0, 0, 4'b1110, 0, 16'h3333, 0, 3, 0);
        add(4'h0, 0, 0, 4'b1110, 1, 16'hA5A5, 0, 0, 0);
        add(4'h0, 0, 0, 4'b1111, 0, 16'hA5A5, 0, 0, 0);
        add(4'h0, 0, 1, 4'b1111, 0, 16'hA5A5, 0, 0, 0);
        add(4'h0, 0, 0, 4'b1111, 0, 16'hA5A5, 0, 0, 0);
        // Invalid mod 1 on channel 2: dropped, never issued
        add(4'h4, 1, 0, 4'b1011, 0, 16'hA5A5, 0, 0, 1);
        add(4'h0, 0, 0, 4'b1111, 0, 16'hA5A5, 0, 0, 0);
        add(4'h0, 0, 0, 4'b1111, 0, 16'hA5A5, 0, 0, 0);
        // Start timeout on channel 1 (mod 5), then proof of return to IDLE
        add(4'h2, 5, 0, 4'b1101, 0, 16'hA5A5, 0, 0, 0);
        add(4'h0, 0, 0, 4'b1101, 1, 16'h1111, 5, 1, 0);
        add(4'h0, 0, 0, 4'b1111, 0, 16'h1111, 5, 1, 0);
        add(4'h0, 0, 0, 4'b1111, 0, 16'h1111, 5, 1, 1);
        add(4'h0, 0, 0, 4'b1111, 0, 16'h1111, 5, 1, 0);
        add(4'h1, 0, 0, 4'b1110, 0, 16'h1111, 5, 1, 0);
        add(4'h0, 0, 0, 4'b1110, 1, 16'hA5A5, 0, 0, 0);
        add(4'h0, 0, 1, 4'b1111, 0, 16'hA5A5, 0, 0, 0);
        add(4'h0, 0, 1, 4'b1111, 0, 16'hA5A5, 0, 0, 0);
        add(4'h0, 0, 0, 4'b1111, 0, 16'hA5A5, 0, 0, 0);

        #1;
        chk("reset", 4'b1111, 0, 16'h0000, 0, 0, 0);
        step();
        rst_i = 1'b0;
        foreach (vq[i]) begin
            req_val_i = vq[i].val;
            req_mod_i = {4{vq[i].mod}};
            ser_busy_i = vq[i].busy;
            step();
            chk($sformatf("vec%0d", i), vq[i].rdy, vq[i].sv, vq[i].sd, vq[i].sm, vq[i].gid, vq[i].drp);
        end

        // Reset while in WAIT_DONE on channel 3
        req_mod_i = '0;
        req_val_i = 4'h8;
        step();
        req_val_i = 4'h0;
        step();
        chk("issue_ch3", 4'b0111, 1, 16'h3333, 0, 3, 0);
        step();
        ser_busy_i = 1'b1;
        step();
        chk("wait_done", 4'b1111, 0, 16'h3333, 0, 3, 0);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst_async", 4'b1111, 0, 16'h0000, 0, 0, 0);
        req_val_i = 4'hF;
        ser_busy_i = 1'b0;
        step();
        chk("rst_hold", 4'b1111, 0, 16'h0000, 0, 0, 0);
        rst_i = 1'b0;
        #1;
        chk("rel0", 4'b1111, 0, 16'h0000, 0, 0, 0);
        step();
        req_val_i = 4'h0;
        chk("rel1", 4'b0000, 0, 16'h0000, 0, 0, 0);
        step();
        chk("rel2", 4'b0000, 1, 16'hA5A5, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
